// File: rtl/dig_spi_pkg.sv
// -----------------------------------------------------------------------------
// dig_spi_pkg
// Shared definitions for the ADC SPI arbiter: FSM state encoding, bus widths
// and the fixed power-up register words written to each ADC.
// Build option: DIG_SPI_ARB_INIT_EN compiles the power-up init sequencer in
// (adds the WAIT_INIT / INIT_XFER states).
// -----------------------------------------------------------------------------
package dig_spi_pkg;

  localparam int DIG_SPI_WR_W = 16;
  localparam int DIG_SPI_RD_W = 8;

  // Init ROM geometry: four distinct words, addressed with a 2-bit index.
  localparam int INIT_ROM_DEPTH = 4;
  localparam int INIT_IDX_W     = 2;

  // Element [0] is written first: soft reset, then three config words.
  localparam logic [INIT_ROM_DEPTH-1:0][DIG_SPI_WR_W-1:0] INIT_WORDS = {
    16'h4400, 16'h4300, 16'h4280, 16'h0001
  };

  typedef enum logic [2:0] {
`ifdef DIG_SPI_ARB_INIT_EN
    ST_WAIT_INIT  = 3'd0,
    ST_INIT_XFER  = 3'd2,
`endif
    ST_IDLE       = 3'd1,
    ST_HOST_XFER  = 3'd3,
    ST_GAP        = 3'd4
  } dig_spi_state_e;

endpackage

// File: rtl/dig_init_rom.sv
// -----------------------------------------------------------------------------
// dig_init_rom
// Combinational lookup of the power-up register word for a given index.
// Ports:
//   idx  - word index within one ADC's init list
//   word - 16-bit register word to send
// -----------------------------------------------------------------------------
module dig_init_rom
  import dig_spi_pkg::*;
(
  input  logic [INIT_IDX_W-1:0]   idx,
  output logic [DIG_SPI_WR_W-1:0] word
);

  assign word = INIT_WORDS[idx];

endmodule

// File: rtl/dig_spi_arbiter.sv
// -----------------------------------------------------------------------------
// dig_spi_arbiter
// Shares the single ADC SPI master between the register-interface host and
// the power-up init sequencer, forces an idle SEN-high gap after every
// transaction and aborts transactions the master never acknowledges.
//
// Build option: DIG_SPI_ARB_INIT_EN
//   defined   - after reset, wait P_INIT_DELAY cycles, then write
//               N_INIT_WORDS words to ADC 0 and then ADC 1 before serving
//               the host.
//   undefined - no init sequencer; host is served from the first cycle
//               after reset release.
//
// Ports:
//   clk, rst        - lclk domain clock, async active-high reset
//   host_req/sel/wr_data, host_ack/rd_data
//                   - host request level (held until host_ack), target ADC,
//                     write word; one-cycle ack pulse and captured read byte
//   spi_req/sel/wr_data, spi_ack/rd_data
//                   - request level to spi_master, ADC select, word; ack
//                     and read byte from spi_master
//   init_done       - init sequence complete (sticky until reset)
//   busy            - FSM is in any state other than IDLE
//   err, err_clr    - sticky timeout flag and its clear
//
// Handshake (spi side): spi_req is a level held high with spi_sel and
// spi_wr_data stable until the cycle spi_ack is sampled high (or the timeout
// expires); spi_req drops on the following edge. The host side mirrors this:
// host_req is a level, host_ack a single-cycle registered pulse.
// -----------------------------------------------------------------------------
module dig_spi_arbiter
  import dig_spi_pkg::*;
#(
  parameter int N_INIT_WORDS = 4,
  parameter int P_INIT_DELAY = 1024,
  parameter int P_GAP_CYCLES = 16,
  parameter int P_TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_req,
  input  logic                    host_sel,
  input  logic [DIG_SPI_WR_W-1:0] host_wr_data,
  output logic                    host_ack,
  output logic [DIG_SPI_RD_W-1:0] host_rd_data,
  output logic                    spi_req,
  output logic                    spi_sel,
  output logic [DIG_SPI_WR_W-1:0] spi_wr_data,
  input  logic                    spi_ack,
  input  logic [DIG_SPI_RD_W-1:0] spi_rd_data,
  output logic                    init_done,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int TO_W  = $clog2(P_TIMEOUT + 1);
  localparam int GAP_W = $clog2(P_GAP_CYCLES + 1);

  // The counters below assume every parameter is at least 1.
  if (P_GAP_CYCLES < 1 || P_TIMEOUT < 1 || N_INIT_WORDS < 1 || P_INIT_DELAY < 1) begin : g_param_check
    $error("dig_spi_arbiter: all timing/count parameters must be >= 1");
  end

  dig_spi_state_e   state;
  logic [TO_W-1:0]  timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             xfer_end;
  logic             xfer_to;

  // Ack takes priority over an expiring timer: a late-but-valid ack is
  // never reported as a timeout.
  assign xfer_to  = !spi_ack && (timer == TO_W'(P_TIMEOUT - 1));
  assign xfer_end = spi_ack || xfer_to;

`ifdef DIG_SPI_ARB_INIT_EN
  localparam int DLY_W = $clog2(P_INIT_DELAY + 1);
  localparam int IDX_W = $clog2(2 * N_INIT_WORDS + 1);
  localparam dig_spi_state_e RESET_STATE = ST_WAIT_INIT;

  logic [DLY_W-1:0]        dly_cnt;
  logic [IDX_W-1:0]        init_idx;   // 0..2N-1 over both ADCs, 2N = finished
  logic                    init_sel;
  logic [INIT_IDX_W-1:0]   rom_idx;
  logic [DIG_SPI_WR_W-1:0] init_word;

  // First N indices go to ADC 0, next N to ADC 1; the ROM index wraps if
  // N_INIT_WORDS exceeds the ROM depth.
  assign init_sel = (init_idx >= IDX_W'(N_INIT_WORDS));
  assign rom_idx  = INIT_IDX_W'(init_sel ? init_idx - IDX_W'(N_INIT_WORDS) : init_idx);

  dig_init_rom u_init_rom (
    .idx  (rom_idx),
    .word (init_word)
  );
`else
  localparam dig_spi_state_e RESET_STATE = ST_IDLE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_STATE;
      timer        <= '0;
      gap_cnt      <= '0;
      spi_req      <= 1'b0;
      spi_sel      <= 1'b0;
      spi_wr_data  <= '0;
      host_ack     <= 1'b0;
      host_rd_data <= '0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
`ifdef DIG_SPI_ARB_INIT_EN
      dly_cnt      <= '0;
      init_idx     <= '0;
`endif
    end else begin
      host_ack <= 1'b0;
      // Clear first so a timeout later in this block overrides it.
      if (err_clr) err <= 1'b0;
`ifndef DIG_SPI_ARB_INIT_EN
      init_done <= 1'b1;
`endif

      case (state)
`ifdef DIG_SPI_ARB_INIT_EN
        ST_WAIT_INIT: begin
          busy <= 1'b1;
          if (dly_cnt == DLY_W'(P_INIT_DELAY - 1)) begin
            dly_cnt     <= '0;
            spi_req     <= 1'b1;
            spi_sel     <= init_sel;
            spi_wr_data <= init_word;
            timer       <= '0;
            state       <= ST_INIT_XFER;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        ST_INIT_XFER: begin
          if (xfer_end) begin
            spi_req  <= 1'b0;
            gap_cnt  <= '0;
            init_idx <= init_idx + 1'b1;
            if (xfer_to) err <= 1'b1;
            state    <= ST_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        ST_IDLE: begin
          if (host_req && init_done) begin
            spi_req     <= 1'b1;
            spi_sel     <= host_sel;
            spi_wr_data <= host_wr_data;
            timer       <= '0;
            busy        <= 1'b1;
            state       <= ST_HOST_XFER;
          end
        end

        ST_HOST_XFER: begin
          if (xfer_end) begin
            spi_req      <= 1'b0;
            gap_cnt      <= '0;
            host_ack     <= 1'b1;
            host_rd_data <= spi_ack ? spi_rd_data : '0;
            if (xfer_to) err <= 1'b1;
            state        <= ST_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(P_GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
`ifdef DIG_SPI_ARB_INIT_EN
            if (!init_done) begin
              // Gap after an init word: launch the next one or finish.
              if (init_idx == IDX_W'(2 * N_INIT_WORDS)) begin
                init_done <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                spi_req     <= 1'b1;
                spi_sel     <= init_sel;
                spi_wr_data <= init_word;
                timer       <= '0;
                state       <= ST_INIT_XFER;
              end
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
`else
            busy  <= 1'b0;
            state <= ST_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          spi_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dig_spi_arbiter.md
# dig_spi_arbiter

Sequences and shares the single ADC serial-interface SPI master between two requesters: the register-interface host path and an autonomous power-up initialisation sequencer that writes a fixed list of register words to both ADCs. It sits between the register block (`dig_sel` / `dig_spi_req` / `dig_spi_wr_data`) and the `spi_master` instance, inserts the minimum SEN-high gap between transactions, and guards against a hung master with a timeout.

## Interface
- `N_INIT_WORDS`, 4: init words written per ADC.
- `P_INIT_DELAY`, 1024: cycles after reset release before the first init transaction.
- `P_GAP_CYCLES`, 16: idle cycles forced after every transaction; `spi_req` stays low.
- `P_TIMEOUT`, 4096: maximum cycles `spi_req` may stay high waiting for `spi_ack`.
- `clk` in 1: single clock, `lclk` domain.
- `rst` in 1: reset, asynchronous, active-high.
- `host_req` in 1: host request level, held high until `host_ack`.
- `host_sel` in 1: target ADC, 0 or 1.
- `host_wr_data` in 16: host SPI write word.
- `host_ack` out 1: one-cycle completion pulse to the host.
- `host_rd_data` out 8: read byte, valid while `host_ack` is high and held afterwards.
- `spi_req` out 1: request to `spi_master` (drives `wr_req`/`rd_req` and SEN decode).
- `spi_sel` out 1: ADC select for SEN decode and MISO mux.
- `spi_wr_data` out 16: word to `spi_master`.
- `spi_ack` in 1: `spi_master` ack.
- `spi_rd_data` in 8: `spi_master` read data.
- `init_done` out 1: init sequence complete.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
- FSM states: WAIT_INIT, IDLE, INIT_XFER, HOST_XFER, GAP.
- After reset the FSM enters WAIT_INIT and counts `P_INIT_DELAY` cycles, then moves to INIT_XFER.
- Init order: ADC 0 words 0..N-1, then ADC 1 words 0..N-1. That is 2·N_INIT_WORDS transactions, each followed by GAP.
- After the last init GAP, `init_done` is set and stays high until reset. The FSM then enters IDLE.
- `host_req` is ignored until `init_done` is high. The host is never granted mid-sequence.
- In IDLE with `host_req` high, the FSM latches `host_sel` and `host_wr_data` into `spi_sel` and `spi_wr_data`, then enters HOST_XFER.
- In XFER states, `spi_req` is held high with `spi_sel` and `spi_wr_data` stable. When `spi_ack` is sampled high, `spi_req` drops and the FSM enters GAP.
- On a host transaction, `spi_rd_data` is captured into `host_rd_data` and `host_ack` pulses in the same cycle that `spi_req` drops.
- Timeout: if `spi_ack` is not seen within `P_TIMEOUT` cycles, `spi_req` drops and `err` is set.
  - For a host transaction, `host_ack` still pulses with `host_rd_data` = 8'h00.
  - For an init transaction, the sequence continues with the next word.
- `err_clr` clears `err`. If a timeout occurs in the same cycle as `err_clr`, the set wins.
- Reset values: `spi_req`, `spi_sel`, `host_ack`, `init_done`, `busy` and `err` are 0; `spi_wr_data` = 16'h0; `host_rd_data` = 8'h0.

## Timing
- Host grant: `host_req` sampled high in IDLE gives `spi_req` high on the next cycle.
- `host_ack` is registered and occurs on the cycle after `spi_ack` is sampled high.
- If `host_req` is still high in the cycle after `host_ack`, it is a new request. It is served after GAP, at the earliest `P_GAP_CYCLES`+1 cycles after `host_ack`.
- GAP lasts exactly `P_GAP_CYCLES` cycles with `spi_req` low.
- If `spi_ack` arrives on the same cycle the timeout counter expires, the ack wins and `err` is not set.
- Asynchronous reset mid-transaction: `spi_req` drops immediately, the timer and init index clear, and init restarts from ADC 0 word 0.
- Counters saturate or wrap only at their terminal values. Use width $clog2 of the maximum parameter+1.

## Configuration
- `DIG_SPI_ARB_INIT_EN` defined:
  - The init sequencer is compiled in as described above.
- `DIG_SPI_ARB_INIT_EN` undefined:
  - WAIT_INIT and INIT_XFER are removed, along with the init ROM and delay counter.
  - The FSM leaves reset directly into IDLE.
  - `init_done` is 0 during reset and 1 from the first cycle after reset release.
  - `N_INIT_WORDS` and `P_INIT_DELAY` are unused.

## Structure
- Shared package `dig_spi_pkg`:
  - FSM state enum.
  - `INIT_WORDS` constant array: 16'h0001 (soft reset), 16'h4280, 16'h4300, 16'h4400.
  - `DIG_SPI_WR_W` = 16 and `DIG_SPI_RD_W` = 8.
- One sub-module, `dig_init_rom`: combinational index → 16-bit word lookup into `INIT_WORDS`. It is instantiated only under `DIG_SPI_ARB_INIT_EN`.

## Test plan
- Reset release with `spi_ack` returned 5 cycles after each `spi_req`: first `spi_req` rises 1024 cycles after release; 8 transactions run with `spi_sel` 0,0,0,0,1,1,1,1 and words 0001/4280/4300/4400 repeated; `init_done` rises after the 8th GAP.
- `host_req`=1 asserted during init: no grant and no `host_ack` until `init_done`; then the first `spi_req` carries `host_wr_data` = 16'h8A55 with `spi_sel` = `host_sel`.
- Host read with `spi_rd_data` = 8'h3C at ack: `host_ack` is a one-cycle pulse with `host_rd_data` = 8'h3C; the next `spi_req` is no earlier than 17 cycles later.
- `spi_ack` never returned: `spi_req` drops after 4096 cycles, `err` = 1, `host_ack` pulses with 8'h00; `err_clr` returns `err` to 0.
- `rst` asserted mid init word 5: `spi_req` drops asynchronously; after release the sequence restarts at ADC 0 word 0 following 1024 cycles.
- Build without `DIG_SPI_ARB_INIT_EN`: `init_done` = 1 one cycle after reset release, and the first host request is granted immediately.
